// File: rtl/rv_pkg.sv
// Shared definitions for the RV core hazard logic: forward-select codes,
// hazard-controller state encoding, register-read bit positions and the
// qualified rd-match helper.
package rv_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned RR_RS1 = 0;
  localparam int unsigned RR_RS2 = 1;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_LDSTALL = 2'd1,
    HZ_MWAIT   = 2'd2
  } hz_state_t;

  // x0 is never a real producer, so a match needs a live writer and rd != 0
  function automatic logic rd_hit(input logic [4:0] rs, input logic [4:0] rd,
                                  input logic we);
    return we && (rd != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/rv_fwd_sel.sv
// EX operand forward select: MEM result wins over WB result, else regfile.
module rv_fwd_sel
  import rv_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  // priority rd match, youngest producer first
  always_comb begin
    sel = FWD_REG;
    if (rd_hit(rs, mem_rd, mem_reg_write)) begin
      sel = FWD_MEM;
    end else if (rd_hit(rs, wb_rd, wb_reg_write)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/rv_hazard_unit.sv
// Pipeline hazard controller for the 5-stage RV core: stall/flush strobes,
// EX forward selects and a saturating stall-cycle counter.
// RV_HAZARD_FWD_EN: when defined, operands are forwarded and only load-use
// stalls; when undefined, any used ID source matching an EX/MEM writer stalls.
module rv_hazard_unit
  import rv_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [1:0]       id_reg_read_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_branch_taken_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_reg_write_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

  hz_state_t  state, state_nx;
  hz_state_t  saved, saved_nx;
  hz_state_t  cur;
  logic [1:0] bub_cnt, bub_nx;
  logic       rs1_used, rs2_used;
  logic       hazard, lds_go, freeze;
  logic [1:0] fwd_a, fwd_b;

  assign rs1_used = id_reg_read_i[RR_RS1];
  assign rs2_used = id_reg_read_i[RR_RS2];

`ifdef RV_HAZARD_FWD_EN
  rv_fwd_sel u_fwd_a (
    .rs            (ex_rs1_i),
    .mem_rd        (mem_rd_i),
    .mem_reg_write (mem_reg_write_i),
    .wb_rd         (wb_rd_i),
    .wb_reg_write  (wb_reg_write_i),
    .sel           (fwd_a)
  );

  rv_fwd_sel u_fwd_b (
    .rs            (ex_rs2_i),
    .mem_rd        (mem_rd_i),
    .mem_reg_write (mem_reg_write_i),
    .wb_rd         (wb_rd_i),
    .wb_reg_write  (wb_reg_write_i),
    .sel           (fwd_b)
  );

  assign hazard = ex_mem_read_i &
                  ((rs1_used & rd_hit(id_rs1_i, ex_rd_i, ex_reg_write_i)) |
                   (rs2_used & rd_hit(id_rs2_i, ex_rd_i, ex_reg_write_i)));
  assign lds_go = (LU_LOAD != 2'd0);
`else
  logic unused_fwd;

  assign fwd_a  = FWD_REG;
  assign fwd_b  = FWD_REG;
  // write-first regfile: a WB producer never needs a stall
  assign hazard = (rs1_used & (rd_hit(id_rs1_i, ex_rd_i, ex_reg_write_i) |
                               rd_hit(id_rs1_i, mem_rd_i, mem_reg_write_i))) |
                  (rs2_used & (rd_hit(id_rs2_i, ex_rd_i, ex_reg_write_i) |
                               rd_hit(id_rs2_i, mem_rd_i, mem_reg_write_i)));
  assign lds_go = 1'b0;
  assign unused_fwd = ^{ex_rs1_i, ex_rs2_i, wb_rd_i, wb_reg_write_i, ex_mem_read_i};
`endif

  // strobes and next state; priority memory wait > load-use > branch
  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    state_nx    = state;
    saved_nx    = saved;
    bub_nx      = bub_cnt;
    freeze      = (state == HZ_MWAIT) ? ~mem_ready_i : (mem_req_i & ~mem_ready_i);
    // the release cycle of a memory wait acts as the saved state, so an owed
    // bubble or a pending load-use under the frozen EX is not skipped
    cur         = (state == HZ_MWAIT) ? saved : state;

    if (freeze) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
      state_nx    = HZ_MWAIT;
      saved_nx    = cur;
    end else if (cur == HZ_LDSTALL) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
      flush_ex_o = 1'b1;
      bub_nx     = (bub_cnt == 2'd0) ? 2'd0 : bub_cnt - 2'd1;
      state_nx   = (bub_cnt <= 2'd1) ? HZ_RUN : HZ_LDSTALL;
    end else if (hazard) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
      flush_ex_o = 1'b1;
      bub_nx     = LU_LOAD;
      state_nx   = lds_go ? HZ_LDSTALL : HZ_RUN;
    end else begin
      state_nx = HZ_RUN;
      if (ex_branch_taken_i) begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end
    end

    fwd_a_o = fwd_a;
    fwd_b_o = fwd_b;

    if (rst) begin
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      stall_ex_o  = 1'b0;
      stall_mem_o = 1'b0;
      flush_id_o  = 1'b0;
      flush_ex_o  = 1'b0;
      fwd_a_o     = FWD_REG;
      fwd_b_o     = FWD_REG;
    end
  end

  // controller state, bubble count and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HZ_RUN;
      saved       <= HZ_RUN;
      bub_cnt     <= '0;
      stall_cnt_o <= '0;
    end else begin
      state   <= state_nx;
      saved   <= saved_nx;
      bub_cnt <= bub_nx;
      if (stall_if_o && !(&stall_cnt_o)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Self-checking bench for rv_hazard_unit: two instances (LU_BUBBLES 1 and 3)
// share stimulus; a cycle model checks every output on each negedge and
// directed literals pin the model on the key scenarios.
`timescale 1ns/1ps
module tb_rv_hazard_unit;

  localparam int unsigned CNT_W = 32;
`ifdef RV_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rs1_i, ex_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i;
  logic [1:0] id_reg_read_i;
  logic ex_reg_write_i, ex_mem_read_i, ex_branch_taken_i;
  logic mem_reg_write_i, mem_req_i, mem_ready_i, wb_reg_write_i;

  logic             sif [2];
  logic             sid [2];
  logic             sex [2];
  logic             smem[2];
  logic             fid [2];
  logic             fex [2];
  logic [1:0]       fa  [2];
  logic [1:0]       fb  [2];
  logic [CNT_W-1:0] cnt [2];

  int errors = 0;
  int checks = 0;

  int owe  [2];
  bit frz  [2];
  int mcnt [2];
  int lu_of[2] = '{1, 3};

  always #5 clk = ~clk;

  rv_hazard_unit #(.LU_BUBBLES(1), .CNT_W(CNT_W)) dut_lu1 (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_reg_read_i(id_reg_read_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_branch_taken_i(ex_branch_taken_i),
    .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i),
    .stall_if_o(sif[0]), .stall_id_o(sid[0]), .stall_ex_o(sex[0]),
    .stall_mem_o(smem[0]), .flush_id_o(fid[0]), .flush_ex_o(fex[0]),
    .fwd_a_o(fa[0]), .fwd_b_o(fb[0]), .stall_cnt_o(cnt[0])
  );

  rv_hazard_unit #(.LU_BUBBLES(3), .CNT_W(CNT_W)) dut_lu3 (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_reg_read_i(id_reg_read_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_branch_taken_i(ex_branch_taken_i),
    .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i),
    .stall_if_o(sif[1]), .stall_id_o(sid[1]), .stall_ex_o(sex[1]),
    .stall_mem_o(smem[1]), .flush_id_o(fid[1]), .flush_ex_o(fex[1]),
    .fwd_a_o(fa[1]), .fwd_b_o(fb[1]), .stall_cnt_o(cnt[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (!FWD) return 2'b00;
    if (mem_reg_write_i && mem_rd_i != 0 && rs == mem_rd_i) return 2'b01;
    if (wb_reg_write_i && wb_rd_i != 0 && rs == wb_rd_i) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit uses(input logic [4:0] r);
    return (id_reg_read_i[0] && id_rs1_i == r) || (id_reg_read_i[1] && id_rs2_i == r);
  endfunction

  function automatic bit hazard_now();
    bit ex_w;
    bit mem_w;
    ex_w  = ex_reg_write_i && ex_rd_i != 0 && uses(ex_rd_i);
    mem_w = mem_reg_write_i && mem_rd_i != 0 && uses(mem_rd_i);
    if (FWD) return ex_w && ex_mem_read_i;
    return ex_w || mem_w;
  endfunction

  // per-cycle compare of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, mw;
      logic [1:0] e_fa, e_fb;
      e_sif = 0; e_sid = 0; e_sex = 0; e_smem = 0; e_fid = 0; e_fex = 0; mw = 0;
      e_fa = 2'b00; e_fb = 2'b00;
      if (rst) begin
        owe[i] = 0; frz[i] = 0; mcnt[i] = 0;
      end else begin
        assert (!(ex_branch_taken_i && owe[i] > 0))
          else $error("branch taken while load-use bubbles are owed");
        e_fa = fwd_of(ex_rs1_i);
        e_fb = fwd_of(ex_rs2_i);
        mw = frz[i] ? !mem_ready_i : (mem_req_i && !mem_ready_i);
        if (mw) begin
          e_sif = 1; e_sid = 1; e_sex = 1; e_smem = 1;
          frz[i] = 1;
        end else begin
          frz[i] = 0;
          if (owe[i] > 0) begin
            e_sif = 1; e_sid = 1; e_fex = 1;
            owe[i]--;
          end else if (hazard_now()) begin
            e_sif = 1; e_sid = 1; e_fex = 1;
            owe[i] = FWD ? lu_of[i] - 1 : 0;
          end else if (ex_branch_taken_i) begin
            e_fid = 1; e_fex = 1;
          end
        end
      end
      chk($sformatf("stall_if lu%0d", lu_of[i]), sif[i], e_sif);
      chk($sformatf("stall_id lu%0d", lu_of[i]), sid[i], e_sid);
      chk($sformatf("stall_ex lu%0d", lu_of[i]), sex[i], e_sex);
      chk($sformatf("stall_mem lu%0d", lu_of[i]), smem[i], e_smem);
      chk($sformatf("flush_id lu%0d", lu_of[i]), fid[i], e_fid);
      chk($sformatf("flush_ex lu%0d", lu_of[i]), fex[i], e_fex);
      chk($sformatf("fwd_a lu%0d", lu_of[i]), fa[i], e_fa);
      chk($sformatf("fwd_b lu%0d", lu_of[i]), fb[i], e_fb);
      chk($sformatf("stall_cnt lu%0d", lu_of[i]), cnt[i], mcnt[i]);
      if (!rst && e_sif) mcnt[i]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_rs1_i = 0; id_rs2_i = 0; id_reg_read_i = 2'b00;
    ex_rs1_i = 0; ex_rs2_i = 0; ex_rd_i = 0;
    ex_reg_write_i = 0; ex_mem_read_i = 0; ex_branch_taken_i = 0;
    mem_rd_i = 0; mem_reg_write_i = 0; mem_req_i = 0; mem_ready_i = 1;
    wb_rd_i = 0; wb_reg_write_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  // lw x5 in EX
  task automatic ld_in_ex();
    ex_rd_i = 5; ex_reg_write_i = 1; ex_mem_read_i = 1;
  endtask

  // add x6,x5,x1 in ID
  task automatic dep_in_id();
    id_rs1_i = 5; id_rs2_i = 1; id_reg_read_i = 2'b11;
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();

    // reset forces every strobe low regardless of inputs
    ld_in_ex(); dep_in_id();
    mem_req_i = 1; mem_ready_i = 0; ex_branch_taken_i = 1;
    ex_rs1_i = 7; ex_rs2_i = 7; mem_rd_i = 7; mem_reg_write_i = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst stall_if", sif[i], 0);
      chk("rst stall_mem", smem[i], 0);
      chk("rst flush_id", fid[i], 0);
      chk("rst flush_ex", fex[i], 0);
      chk("rst fwd_a", fa[i], 0);
      chk("rst cnt", cnt[i], 0);
    end
    cyc();

    // load-use: lw x5 ; add x6,x5,x1
    do_reset();
    ld_in_ex(); dep_in_id(); #1;
    chk("lu c1 stall_if lu1", sif[0], 1);
    chk("lu c1 flush_ex lu1", fex[0], 1);
    chk("lu c1 stall_ex lu1", sex[0], 0);
    chk("lu c1 stall_if lu3", sif[1], 1);
    cyc();
    idle(); dep_in_id(); mem_rd_i = 5; mem_reg_write_i = 1; #1;
    chk("lu c2 stall_if lu1", sif[0], FWD ? 0 : 1);
    cyc();
    idle(); ex_rs1_i = 5; ex_rs2_i = 1; ex_rd_i = 6; ex_reg_write_i = 1;
    wb_rd_i = 5; wb_reg_write_i = 1; #1;
    chk("lu c3 fwd_a lu1", fa[0], FWD ? 2'b10 : 2'b00);
    chk("lu c3 fwd_b lu1", fb[0], 2'b00);
    chk("lu c3 stall_if lu3", sif[1], FWD ? 1 : 0);
    cyc();
    idle(); #1;
    chk("lu cnt lu1", cnt[0], FWD ? 1 : 2);
    chk("lu cnt lu3", cnt[1], FWD ? 3 : 2);
    chk("lu done stall_if lu3", sif[1], 0);
    cyc();

    // back-to-back ALU: add x3 ; sub x4,x3,x3
    do_reset();
    ex_rd_i = 3; ex_reg_write_i = 1; id_rs1_i = 3; id_rs2_i = 3; id_reg_read_i = 2'b11; #1;
    chk("alu c1 stall_if", sif[0], FWD ? 0 : 1);
    cyc();
`ifdef RV_HAZARD_FWD_EN
    idle(); mem_rd_i = 3; mem_reg_write_i = 1;
    ex_rs1_i = 3; ex_rs2_i = 3; ex_rd_i = 4; ex_reg_write_i = 1; #1;
    chk("alu fwd_a", fa[0], 2'b01);
    chk("alu fwd_b", fb[0], 2'b01);
    chk("alu c2 stall_if", sif[0], 0);
    cyc();
`else
    idle(); mem_rd_i = 3; mem_reg_write_i = 1;
    id_rs1_i = 3; id_rs2_i = 3; id_reg_read_i = 2'b11; #1;
    chk("alu c2 stall_if", sif[0], 1);
    cyc();
    idle(); wb_rd_i = 3; wb_reg_write_i = 1;
    id_rs1_i = 3; id_rs2_i = 3; id_reg_read_i = 2'b11; #1;
    chk("alu c3 stall_if", sif[0], 0);
    cyc();
    idle(); ex_rs1_i = 3; ex_rs2_i = 3; ex_rd_i = 4; ex_reg_write_i = 1; #1;
    chk("alu fwd_a", fa[0], 2'b00);
    chk("alu fwd_b", fb[0], 2'b00);
    cyc();
`endif
    idle(); #1;
    chk("alu cnt", cnt[0], FWD ? 0 : 2);
    cyc();

    // x0 writer: lw x0 ; add x1,x0,x0
    do_reset();
    ex_rd_i = 0; ex_reg_write_i = 1; ex_mem_read_i = 1;
    id_rs1_i = 0; id_rs2_i = 0; id_reg_read_i = 2'b11; #1;
    chk("x0 c1 stall_if lu1", sif[0], 0);
    chk("x0 c1 stall_if lu3", sif[1], 0);
    cyc();
    idle(); mem_rd_i = 0; mem_reg_write_i = 1;
    ex_rs1_i = 0; ex_rs2_i = 0; ex_rd_i = 1; ex_reg_write_i = 1; #1;
    chk("x0 fwd_a", fa[0], 0);
    chk("x0 fwd_b", fb[0], 0);
    cyc();
    idle(); #1;
    chk("x0 cnt", cnt[1], 0);
    cyc();

    // memory wait during the load-use bubbles (LU_BUBBLES=3 instance)
    do_reset();
    ld_in_ex(); dep_in_id();
    cyc();
    for (int k = 0; k < 4; k++) begin
      idle(); dep_in_id(); mem_rd_i = 5; mem_reg_write_i = 1;
      mem_req_i = 1; mem_ready_i = 0; #1;
      chk("mw freeze stall_mem lu3", smem[1], 1);
      chk("mw freeze flush_ex lu3", fex[1], 0);
      cyc();
    end
    idle(); dep_in_id(); mem_rd_i = 5; mem_reg_write_i = 1;
    mem_req_i = 1; mem_ready_i = 1; #1;
    chk("mw release stall_mem lu3", smem[1], 0);
    cyc();
    idle(); dep_in_id(); wb_rd_i = 5; wb_reg_write_i = 1; #1;
    chk("mw last bubble lu3", sif[1], FWD ? 1 : 0);
    cyc();
    idle(); ex_rs1_i = 5; ex_rs2_i = 1; ex_rd_i = 6; ex_reg_write_i = 1; #1;
    chk("mw after stall_if lu3", sif[1], 0);
    cyc();
    idle(); #1;
    chk("mw cnt lu3", cnt[1], FWD ? 7 : 6);
    cyc();

    // branch flush in RUN and during a memory wait
    do_reset();
    ex_branch_taken_i = 1; #1;
    chk("br flush_id", fid[0], 1);
    chk("br flush_ex", fex[0], 1);
    cyc();
    idle(); #1;
    chk("br after flush_id", fid[0], 0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      idle(); mem_req_i = 1; mem_ready_i = 0; ex_branch_taken_i = 1; #1;
      chk("br mw flush_id", fid[0], 0);
      chk("br mw stall_ex", sex[0], 1);
      cyc();
    end
    idle(); mem_req_i = 1; mem_ready_i = 1; ex_branch_taken_i = 1; #1;
    chk("br release flush_id", fid[0], 1);
    chk("br release flush_ex", fex[0], 1);
    chk("br release stall_if", sif[0], 0);
    cyc();
    idle(); cyc();

    // reset in the middle of the load-use bubbles
    do_reset();
    ld_in_ex(); dep_in_id();
    cyc();
    idle(); dep_in_id(); mem_rd_i = 5; mem_reg_write_i = 1;
    rst = 1; #1;
    chk("rst mid stall_if lu3", sif[1], 0);
    chk("rst mid flush_ex lu3", fex[1], 0);
    chk("rst mid cnt lu3", cnt[1], 0);
    cyc();
    rst = 0; idle(); ex_branch_taken_i = 1; #1;
    chk("post rst stall_if lu3", sif[1], 0);
    chk("post rst flush_id lu3", fid[1], 1);
    chk("post rst cnt lu3", cnt[1], 0);
    cyc();
    idle(); cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_hazard_unit.md
# rv_hazard_unit

Pipeline hazard controller for the 5-stage RV core. It takes the decoded ID-stage register usage from the control path and the destination info of later stages. From these it generates the per-stage stall and flush strobes, the EX operand forwarding selects, and a stall-cycle counter. It sits beside `rv_ctrl`, between the decode stage and the pipeline registers, and is the only block that holds or bubbles the pipeline.

## Interface
- `LU_BUBBLES`, default 1: bubbles inserted on a load-use hazard. Legal range is 1..3.
- `CNT_W`, default 32: width of the stall counter.

Ports:
- `clk` in 1: core clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs1_i`, `id_rs2_i` in 5 each: source registers of the instruction in ID.
- `id_reg_read_i` in 2: register-read code from the control path. bit0 means rs1 is used; bit1 means rs2 is used (01 = rs1 only, 11 = both).
- `ex_rs1_i`, `ex_rs2_i` in 5 each: source registers of the instruction in EX.
- `ex_rd_i` in 5, `ex_reg_write_i` in 1, `ex_mem_read_i` in 1: destination info of the EX instruction.
- `ex_branch_taken_i` in 1: a branch or JAL in EX redirects the PC this cycle.
- `mem_rd_i` in 5, `mem_reg_write_i` in 1: destination info of the MEM instruction.
- `mem_req_i` in 1, `mem_ready_i` in 1: data-memory access in MEM, and its completion.
- `wb_rd_i` in 5, `wb_reg_write_i` in 1: destination info of the WB instruction.
- `stall_if_o` out 1: hold the PC and IF/ID.
- `stall_id_o` out 1: hold ID/EX.
- `stall_ex_o` out 1: hold EX/MEM.
- `stall_mem_o` out 1: hold MEM/WB.
- `flush_id_o` out 1: zero IF/ID.
- `flush_ex_o` out 1: load a bubble into ID/EX.
- `fwd_a_o`, `fwd_b_o` out 2 each: EX operand select. 00 = register file, 01 = MEM result, 10 = WB result.
- `stall_cnt_o` out `CNT_W`: number of cycles with `stall_if_o` high. Saturates at all-ones.

## Operation
- Register x0 never creates a hazard or a forward. Every rd match is qualified by rd != 0 and the relevant reg_write signal.
- **Forwarding.** For each EX source, MEM wins over WB: select 01 on a MEM match, else 10 on a WB match, else 00.
- **Load-use hazard.** Fires when `ex_mem_read_i` is high and `ex_rd_i` matches an ID source that `id_reg_read_i` marks as used.
- **State machine**, states RUN, LDSTALL, MWAIT:
  - RUN, memory wait (`mem_req_i & ~mem_ready_i`): freeze. All four stall outputs high, flushes low. Go to MWAIT.
  - RUN, load-use hazard: `stall_if_o`, `stall_id_o` and `flush_ex_o` high. Load `bub_cnt = LU_BUBBLES-1`. Go to LDSTALL if the loaded value is nonzero, else stay in RUN.
  - RUN, `ex_branch_taken_i`: `flush_id_o` and `flush_ex_o` high, no stall.
  - LDSTALL: `stall_if_o`, `stall_id_o` and `flush_ex_o` high, and `bub_cnt` decrements. Return to RUN when `bub_cnt` is 0.
  - MWAIT: all stalls high. On `mem_ready_i`, release the stalls in that same cycle and return to the saved state (RUN or LDSTALL). The saved `bub_cnt` is kept.
- **Priority:** memory wait > load-use > branch.
  - A taken branch during a memory wait is not flushed. The frozen EX instruction re-presents it on release.
- A memory wait arriving in LDSTALL freezes `bub_cnt`.
- `ex_branch_taken_i` in LDSTALL cannot occur, because EX holds a bubble. It is ignored, and the bench asserts it never happens.
- The stall counter increments each cycle that `stall_if_o` is high.

## Timing
- All strobes and forward selects are combinational from the current state and inputs, with zero latency.
- State, `bub_cnt` and `stall_cnt_o` are registered.
- While `rst` is high:
  - State is RUN, `bub_cnt` is 0, `stall_cnt_o` is 0.
  - All stall and flush outputs are 0 and `fwd_a_o`/`fwd_b_o` are 00, regardless of inputs.
- Reset mid-stall abandons the stall immediately. No bubble completes after reset.
- Load-use penalty is exactly `LU_BUBBLES` cycles of `stall_if_o`, plus any memory-wait cycles.
- Memory-wait penalty is exactly the number of cycles with `mem_ready_i` low while `mem_req_i` is high.

## Configuration
- `RV_HAZARD_FWD_EN` defined: forwarding as above. Only the load-use case stalls.
- `RV_HAZARD_FWD_EN` undefined:
  - `fwd_a_o`/`fwd_b_o` are tied to 00.
  - Any used ID source matching an EX or MEM writer asserts `stall_if_o`, `stall_id_o` and `flush_ex_o` each cycle until the match clears.
  - The register file is write-first, so a WB match does not stall.
  - LDSTALL is never entered; the load-use case is covered by the EX/MEM match.
  - Memory-wait and branch behaviour are unchanged.

## Structure
- Shared package `rv_pkg` holds:
  - the forward-select constants `FWD_REG`/`FWD_MEM`/`FWD_WB`;
  - the state encoding `HZ_RUN`/`HZ_LDSTALL`/`HZ_MWAIT`;
  - the `id_reg_read_i` bit positions.
- One natural sub-module: `rv_fwd_sel`, a purely combinational rd-match and priority select, instantiated once per EX operand.

## Test plan
- **Load-use.** Setup: `lw x5`, then `add x6,x5,x1`, with `LU_BUBBLES`=1. Required response: one cycle of `stall_if_o`/`flush_ex_o`, then `fwd_a_o`=10, and `stall_cnt_o` = 1. Repeat with `LU_BUBBLES`=3: exactly 3 stall cycles.
- **Back-to-back ALU.** Setup: `add x3`, then `sub x4,x3,x3`. Required response: `fwd_a_o`=`fwd_b_o`=01 and no stall. With the macro undefined: 2 stall cycles, forward selects 00.
- **x0 writer.** Setup: `lw x0`, then `add x1,x0,x0`. Required response: no stall and forward selects 00.
- **Memory wait during LDSTALL.** Setup: `LU_BUBBLES`=3, then `mem_ready_i` low for 4 cycles starting at the second bubble. Required response: all stalls high for those 4 cycles, then 2 more bubble cycles, and `stall_cnt_o` = 7.
- **Branch flush.**
  - `ex_branch_taken_i` pulse in RUN: `flush_id_o`=`flush_ex_o`=1 for that cycle only.
  - The same pulse during a memory wait: no flush until the cycle `mem_ready_i` rises.
- **Reset mid-stall.** Setup: assert `rst` in LDSTALL with `bub_cnt`=2. Required response: all outputs 0 immediately, state RUN after release, `stall_cnt_o`=0.
